// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the CPU datapath (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, busy_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, busy_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with req/ack handshake and programmable wait states.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_mem_responder_if.slave  dmem
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_capture;
  logic              w_access;

  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;

  logic              w_acc_we;
  logic [31:0]       w_acc_addr;
  logic [31:0]       w_acc_wdata;
  logic [IDX_W-1:0]  w_idx;
  logic              w_misaligned;
  logic              w_unused;

  logic [31:0]       r_mem [DEPTH];
  logic              r_ack;
  logic              r_busy;
  logic [31:0]       r_rdata;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and access-strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dmem.req_i) begin
          w_capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_access    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_nxt   = WAIT_INIT;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_access    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // With zero wait states the access happens on the capture edge, so use the live inputs
  assign w_acc_we    = (r_state == S_IDLE) ? dmem.we_i    : r_we;
  assign w_acc_addr  = (r_state == S_IDLE) ? dmem.addr_i  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? dmem.wdata_i : r_wdata;
  assign w_idx       = w_acc_addr[IDX_W+1:2];
  assign w_unused    = ^{w_acc_addr[31:IDX_W+2], w_acc_addr[1:0], r_addr};

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;

  assign w_misaligned = |w_acc_addr[1:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_RESP) && (|r_addr[1:0]);
    end
  end

  assign dmem.err_o = r_err;
`else
  assign w_misaligned = 1'b0;
  assign dmem.err_o   = 1'b0;
`endif

  // Counter, captured request and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_ack  <= (r_state == S_RESP);
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_capture) begin
        r_we    <= dmem.we_i;
        r_addr  <= dmem.addr_i;
        r_wdata <= dmem.wdata_i;
      end
      if (w_access && !w_acc_we) begin
        r_rdata <= w_misaligned ? 32'h0 : r_mem[w_idx];
      end
    end
  end

  // Word array; not reset, and never written while reset is held
  always_ff @(posedge clk_i) begin
    if (rst_i && w_access && w_acc_we && !w_misaligned) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

  assign dmem.ack_o   = r_ack;
  assign dmem.busy_o  = r_busy;
  assign dmem.rdata_o = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, corner sequences, random vs. model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
  localparam int unsigned TB_WAIT = 0;
  localparam bit ALIGN = 1'b1;
`else
  localparam int unsigned TB_WAIT = 2;
  localparam bit ALIGN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  data_mem_responder_if dmem ();

  data_mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (TB_WAIT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .dmem  (dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain word array plus the last read value
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] exp_rd, output logic exp_err);
    int  idx;
    bit  mis;
    idx = int'(addr[IDX_W+1:2]);
    mis = ALIGN && (addr[1:0] != 2'b00);
    if (we) begin
      if (!mis) m_mem[idx] = wdata;
    end else begin
      m_rdata = mis ? 32'h0 : m_mem[idx];
    end
    exp_rd  = m_rdata;
    exp_err = mis;
  endtask

  // One complete transaction; checks latency, busy duration and ack width
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit scramble, output logic [31:0] rd, output logic er);
    int lat;
    int busy_cnt;
    bit got;
    lat = 0; busy_cnt = 0; got = 1'b0;
    rd = 32'hx; er = 1'bx;
    @(negedge clk);
    dmem.req_i   = 1'b1;
    dmem.we_i    = we;
    dmem.addr_i  = addr;
    dmem.wdata_i = wdata;
    @(posedge clk); #1;
    for (int k = 0; k < 40 && !got; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (scramble && k == 0) begin
        dmem.we_i    = ~we;
        dmem.addr_i  = $urandom;
        dmem.wdata_i = $urandom;
      end
      if (dmem.ack_o) begin
        got = 1'b1;
        lat = k;
        rd  = dmem.rdata_o;
        er  = dmem.err_o;
        dmem.req_i = 1'b0;
      end else if (dmem.busy_o) begin
        busy_cnt++;
      end
    end
    dmem.req_i = 1'b0;
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL ack_timeout addr=%h got=no_ack exp=ack", addr);
    end else begin
      chk("ack_latency", 32'(lat), 32'(TB_WAIT + 1));
      chk("busy_cycles", 32'(busy_cnt), 32'(TB_WAIT + 1));
      @(posedge clk); #1;
      chk("ack_one_cycle", 32'(dmem.ack_o), 32'h0);
    end
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit scramble, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        er;
    do_txn(we, addr, wdata, scramble, rd, er);
    model_txn(we, addr, wdata, exp_rd, exp_err);
    chk(we ? "sw_rdata_hold" : "lw_rdata", rd, exp_rd);
    chk("err_flag", 32'(er), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          acks;
    int          last;
    int          extra;

    checks = 0;
    errors = 0;
    m_rdata = 32'h0;
    dmem.req_i = 1'b0; dmem.we_i = 1'b0; dmem.addr_i = '0; dmem.wdata_i = '0;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0000_0204, 32'h0,         32'h1234_5678};
    vecs[4] = '{1'b1, 32'h0000_0008, 32'h1111_2222, 32'h1234_5678};
    vecs[5] = '{1'b0, 32'h0000_0008, 32'h0,         32'h1111_2222};
    vecs[6] = '{1'b1, 32'h0000_01FC, 32'hCAFE_F00D, 32'h1111_2222};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'hCAFE_F00D};
    vecs[8] = '{1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 32'hCAFE_F00D};
    vecs[9] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5};

    // Reset, then idle for 10 cycles
    rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(dmem.ack_o), 32'h0);
    chk("rst_busy", 32'(dmem.busy_o), 32'h0);
    chk("rst_rdata", dmem.rdata_o, 32'h0);
    chk("rst_err", 32'(dmem.err_o), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_ack", 32'(dmem.ack_o), 32'h0);
      chk("idle_busy", 32'(dmem.busy_o), 32'h0);
      chk("idle_rdata", dmem.rdata_o, 32'h0);
    end

    // Preload every word so the model is fully defined
    for (int i = 0; i < int'(DEPTH); i++) begin
      run(1'b1, 32'(i) << 2, (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000, 1'b0, rd);
    end

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, rd);
      chk("table_rdata", rd, vecs[i].exp_rdata);
    end

    // Held request: three back-to-back reads of 0x10
    @(negedge clk);
    dmem.req_i = 1'b1; dmem.we_i = 1'b0; dmem.addr_i = 32'h10;
    acks = 0; last = -1;
    for (int c = 0; c < 200 && acks < 3; c++) begin
      @(posedge clk); #1;
      if (dmem.ack_o) begin
        acks++;
        model_txn(1'b0, 32'h10, 32'h0, exp_rd, exp_err);
        chk("held_rdata", dmem.rdata_o, exp_rd);
        if (last >= 0) chk("held_gap", 32'(c - last - 1), 32'(TB_WAIT + 1));
        last = c;
        if (acks == 3) dmem.req_i = 1'b0;
      end
    end
    dmem.req_i = 1'b0;
    chk("held_acks", 32'(acks), 32'd3);
    extra = 0;
    for (int c = 0; c < 3 * int'(TB_WAIT + 2); c++) begin
      @(posedge clk); #1;
      if (dmem.ack_o) extra++;
    end
    chk("held_extra_acks", 32'(extra), 32'h0);

    // Inputs scrambled after capture must not affect the result
    run(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b1, rd);
    run(1'b0, 32'h0000_0020, 32'h0, 1'b1, rd);
    run(1'b0, 32'h0000_0024, 32'h0, 1'b0, rd);

    // Reset pulsed right after the write is sampled
    run(1'b0, 32'h0000_0010, 32'h0, 1'b0, rd);
    @(negedge clk);
    dmem.req_i = 1'b1; dmem.we_i = 1'b1; dmem.addr_i = 32'h8; dmem.wdata_i = 32'hAAAA_AAAA;
    @(posedge clk); #2;
    rst_n = 1'b0;
    dmem.req_i = 1'b0;
    #1;
    if (TB_WAIT == 0) m_mem[2] = 32'hAAAA_AAAA;
    m_rdata = 32'h0;
    chk("midrst_ack", 32'(dmem.ack_o), 32'h0);
    chk("midrst_busy", 32'(dmem.busy_o), 32'h0);
    chk("midrst_rdata", dmem.rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 2 * int'(TB_WAIT + 2); c++) begin
      @(posedge clk); #1;
      if (dmem.ack_o) extra++;
    end
    chk("midrst_no_ack", 32'(extra), 32'h0);
    run(1'b0, 32'h0000_0008, 32'h0, 1'b0, rd);

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned accesses: write suppressed, read returns zero, err with ack
    run(1'b0, 32'h0000_0004, 32'h0, 1'b0, rd);
    run(1'b1, 32'h0000_0006, 32'hFFFF_0000, 1'b0, rd);
    run(1'b0, 32'h0000_0004, 32'h0, 1'b0, rd);
    run(1'b0, 32'h0000_0002, 32'h0, 1'b0, rd);
    chk("align_lw_zero", rd, 32'h0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      run(1'($urandom_range(1)), a, $urandom, 1'($urandom_range(1)), rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
